// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary-to-BCD converter for the 4-digit display
module bin2bcd_seq #(
  parameter int BIN_W    = 14,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic [15:0]      bcd,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int               CNT_W     = $clog2(BIN_W + 1);
  localparam logic [15:0]      BCD_RST   = BLANK_LZ ? 16'hFFF0 : 16'h0000;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [BIN_W-1:0] bin_reg;
  logic [15:0]      scratch;
  logic [CNT_W-1:0] step_cnt;
  logic             ovf_mark;
  logic             in_range;
  logic [15:0]      corrected;
  logic [15:0]      scratch_shift;
  logic [15:0]      blanked;
  logic             blank3;
  logic             blank2;
  logic             blank1;

  // Four digits hold at most 9999; anything larger is shown blank with overflow.
  assign in_range = (32'(bin) <= 32'd9999);

  // Busy covers both the shifting steps and the single FINISH cycle.
  assign busy = (state != IDLE);

  // Add-3 correction: each nibble is corrected on its own, carries never cross nibbles.
  always_comb begin
    corrected = scratch;
    for (int i = 0; i < 4; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        corrected[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // One double-dabble step: the MSB of the binary register enters the scratch LSB.
  assign scratch_shift = {corrected[14:0], bin_reg[BIN_W-1]};

  // Leading-zero blanking from digit 3 downward; digit 0 always shows.
  always_comb begin
    blanked = scratch;
    blank3  = BLANK_LZ && (scratch[15:12] == 4'd0);
    blank2  = blank3 && (scratch[11:8] == 4'd0);
    blank1  = blank2 && (scratch[7:4] == 4'd0);
    if (blank3) blanked[15:12] = 4'hF;
    if (blank2) blanked[11:8]  = 4'hF;
    if (blank1) blanked[7:4]   = 4'hF;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: out-of-range values skip the shift phase entirely.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = in_range ? SHIFT : FINISH;
        end
      end
      SHIFT: begin
        if (step_cnt == LAST_STEP) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: capture on start, shift per step, publish result only at FINISH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd      <= BCD_RST;
      done     <= 1'b0;
      overflow <= 1'b0;
      bin_reg  <= '0;
      scratch  <= '0;
      step_cnt <= '0;
      ovf_mark <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_reg  <= bin;
            scratch  <= '0;
            step_cnt <= '0;
            overflow <= 1'b0;
            ovf_mark <= !in_range;
          end
        end
        SHIFT: begin
          scratch  <= scratch_shift;
          bin_reg  <= bin_reg << 1;
          step_cnt <= step_cnt + CNT_W'(1);
        end
        FINISH: begin
          done <= 1'b1;
          if (ovf_mark) begin
            bcd      <= 16'hFFFF;
            overflow <= 1'b1;
          end else begin
            bcd <= blanked;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - table-driven bench for bin2bcd_seq with both blanking settings
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [13:0] bin;
  logic [15:0] bcd1, bcd0;
  logic        busy1, busy0, done1, done0, ovf1, ovf0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          v;
    logic [15:0] e_blank;
    logic [15:0] e_zero;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(14), .BLANK_LZ(1'b1)) dut_blank (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .bcd(bcd1), .busy(busy1), .done(done1), .overflow(ovf1)
  );

  bin2bcd_seq #(.BIN_W(14), .BLANK_LZ(1'b0)) dut_zero (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .bcd(bcd0), .busy(busy0), .done(done0), .overflow(ovf0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Pulse start for one edge; returns at the negedge just after the accepting edge.
  task automatic launch(input int v);
    @(negedge clk);
    start = 1'b1;
    bin   = 14'(v);
    @(negedge clk);
    start = 1'b0;
  endtask

  // lat = edges after the accepting edge until done is seen; bc = sampled busy cycles.
  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (!done1 && lat < 40) begin
      if (busy1) bc++;
      @(negedge clk);
      lat++;
    end
    if (!done1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: got no done, required done within 40 cycles");
    end
  endtask

  initial begin
    int lat, bc, dcnt;

    vecs[0] = '{1234,  16'h1234, 16'h1234, 1'b0};
    vecs[1] = '{305,   16'hF305, 16'h0305, 1'b0};
    vecs[2] = '{0,     16'hFFF0, 16'h0000, 1'b0};
    vecs[3] = '{9999,  16'h9999, 16'h9999, 1'b0};
    vecs[4] = '{10000, 16'hFFFF, 16'hFFFF, 1'b1};
    vecs[5] = '{16383, 16'hFFFF, 16'hFFFF, 1'b1};
    vecs[6] = '{42,    16'hFF42, 16'h0042, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("reset_bcd_blank", 32'(bcd1), 32'hFFF0);
    check("reset_bcd_zero",  32'(bcd0), 32'h0000);
    check("reset_busy", 32'({busy1, busy0}), 32'd0);
    check("reset_done", 32'({done1, done0}), 32'd0);
    check("reset_ovf",  32'({ovf1, ovf0}), 32'd0);

    for (int i = 0; i < 7; i++) begin
      launch(vecs[i].v);
      wait_done(lat, bc);
      check($sformatf("lat_%0d", vecs[i].v), 32'(lat), vecs[i].e_ovf ? 32'd1 : 32'd15);
      check($sformatf("busy_cycles_%0d", vecs[i].v), 32'(bc), vecs[i].e_ovf ? 32'd1 : 32'd15);
      check($sformatf("bcd_blank_%0d", vecs[i].v), 32'(bcd1), 32'(vecs[i].e_blank));
      check($sformatf("bcd_zero_%0d", vecs[i].v),  32'(bcd0), 32'(vecs[i].e_zero));
      check($sformatf("ovf_%0d", vecs[i].v), 32'({ovf1, ovf0}), vecs[i].e_ovf ? 32'd3 : 32'd0);
      check($sformatf("busy_at_done_%0d", vecs[i].v), 32'(busy1), 32'd0);
      @(negedge clk);
      check($sformatf("done_pulse_%0d", vecs[i].v), 32'({done1, done0}), 32'd0);
    end

    // start re-pulsed mid-conversion must be ignored.
    launch(1234);
    repeat (4) @(negedge clk);
    start = 1'b1;
    bin   = 14'd7;
    @(negedge clk);
    start = 1'b0;
    lat   = 5;
    while (!done1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("repulse_lat", 32'(lat), 32'd15);
    check("repulse_bcd", 32'(bcd1), 32'h1234);

    // start held during the done cycle is accepted at once.
    start = 1'b1;
    bin   = 14'd77;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    check("b2b_lat", 32'(lat), 32'd15);
    check("b2b_bcd_blank", 32'(bcd1), 32'hFF77);
    check("b2b_bcd_zero",  32'(bcd0), 32'h0077);

    // Reset in the middle of a conversion abandons it without a done pulse.
    launch(4321);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done1 || done0) dcnt++;
      @(negedge clk);
    end
    check("midrst_no_done", 32'(dcnt), 32'd0);
    check("midrst_bcd_blank", 32'(bcd1), 32'hFFF0);
    check("midrst_bcd_zero",  32'(bcd0), 32'h0000);
    check("midrst_busy", 32'({busy1, busy0}), 32'd0);
    launch(4321);
    wait_done(lat, bc);
    check("after_rst_lat", 32'(lat), 32'd15);
    check("after_rst_bcd_blank", 32'(bcd1), 32'h4321);
    check("after_rst_bcd_zero",  32'(bcd0), 32'h4321);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
